// File: rtl/sram_burst_master_if.sv
// Bundle of request, write-stream, read-stream, status and SRAM-port signals
// shared by sram_burst_master (master side) and its client/SRAM (slave side).
interface sram_burst_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;

  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;

  logic                  done;
  logic                  err;

  logic                  mem_wren;
  logic                  mem_rden;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport master (
    input  req_valid, req_write, req_addr, req_len,
    input  wr_valid, wr_data,
    input  rd_ready,
    input  mem_rd_data,
    output req_ready, wr_ready,
    output rd_valid, rd_data, rd_last,
    output done, err,
    output mem_wren, mem_rden, mem_addr, mem_wr_data
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len,
    output wr_valid, wr_data,
    output rd_ready,
    output mem_rd_data,
    input  req_ready, wr_ready,
    input  rd_valid, rd_data, rd_last,
    input  done, err,
    input  mem_wren, mem_rden, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/sram_burst_master.sv
// Burst initiator for the single-port sram: one access per beat, incrementing address.
// Optional macro SRAM_BURST_BOUNDARY_CHECK_EN rejects bursts that would cross the top address.
module sram_burst_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                clk,
  input  logic                rstn,
  sram_burst_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_next;
  logic [LEN_WIDTH-1:0]  beats_left, beats_left_next;
  logic                  rd_valid, rd_valid_next;
  logic                  rd_last, rd_last_next;
  logic                  done, done_next;
  logic                  wr_beat;
  logic                  rd_issue;

`ifdef SRAM_BURST_BOUNDARY_CHECK_EN
  logic                  err, err_next;
  logic [ADDR_WIDTH:0]   req_end;
  logic                  req_oob;

  // Carry out of addr+len means the last beat would wrap past the top address.
  assign req_end = {1'b0, bus.req_addr} + (ADDR_WIDTH+1)'(bus.req_len);
  assign req_oob = req_end[ADDR_WIDTH];
`endif

  assign wr_beat  = (state == WRITE) && bus.wr_valid;
  // A read is issued only when the output slot is empty or being drained this cycle.
  assign rd_issue = (state == READ) && (!rd_valid || bus.rd_ready);

  always_comb begin
    // NOTE: every next value gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_next      = state;
    cur_addr_next   = cur_addr;
    beats_left_next = beats_left;
    rd_valid_next   = rd_valid;
    rd_last_next    = rd_last;
    done_next       = 1'b0;
`ifdef SRAM_BURST_BOUNDARY_CHECK_EN
    err_next        = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (bus.req_valid) begin
`ifdef SRAM_BURST_BOUNDARY_CHECK_EN
          if (req_oob) begin
            err_next = 1'b1;
          end else
`endif
          begin
            cur_addr_next   = bus.req_addr;
            beats_left_next = bus.req_len;
            state_next      = bus.req_write ? WRITE : READ;
          end
        end
      end

      WRITE: begin
        if (wr_beat) begin
          cur_addr_next   = cur_addr + ADDR_WIDTH'(1);
          beats_left_next = beats_left - LEN_WIDTH'(1);
          if (beats_left == '0) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end

      READ: begin
        if (rd_issue) begin
          rd_valid_next   = 1'b1;
          rd_last_next    = (beats_left == '0);
          cur_addr_next   = cur_addr + ADDR_WIDTH'(1);
          beats_left_next = beats_left - LEN_WIDTH'(1);
          if (beats_left == '0) state_next = DRAIN;
        end
      end

      DRAIN: begin
        if (rd_valid && bus.rd_ready) begin
          rd_valid_next = 1'b0;
          rd_last_next  = 1'b0;
          done_next     = 1'b1;
          state_next    = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cur_addr   <= '0;
      beats_left <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      done       <= 1'b0;
`ifdef SRAM_BURST_BOUNDARY_CHECK_EN
      err        <= 1'b0;
`endif
    end else begin
      // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
      state      <= state_next;
      cur_addr   <= cur_addr_next;
      beats_left <= beats_left_next;
      rd_valid   <= rd_valid_next;
      rd_last    <= rd_last_next;
      done       <= done_next;
`ifdef SRAM_BURST_BOUNDARY_CHECK_EN
      err        <= err_next;
`endif
    end
  end

  assign bus.req_ready   = (state == IDLE);
  assign bus.wr_ready    = (state == WRITE);
  assign bus.mem_wren    = wr_beat;
  assign bus.mem_rden    = rd_issue;
  assign bus.mem_addr    = cur_addr;
  assign bus.mem_wr_data = bus.wr_data;
  // The sram holds its output while rden is low, so read data passes straight through.
  assign bus.rd_data     = bus.mem_rd_data;
  assign bus.rd_valid    = rd_valid;
  assign bus.rd_last     = rd_last;
  assign bus.done        = done;
`ifdef SRAM_BURST_BOUNDARY_CHECK_EN
  assign bus.err         = err;
`else
  assign bus.err         = 1'b0;
`endif

endmodule

// File: tb/tb_sram_burst_master.sv
// Directed bench for sram_burst_master: cycle-vector table for a write/read pair,
// then hand sequences for stalls, write gaps, address wrap and mid-burst reset.
module tb_sram_burst_master;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LW = 4;

  typedef struct {
    logic          req_valid;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_len;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          rd_ready;
    logic          e_req_ready;
    logic          e_wr_ready;
    logic          e_wren;
    logic          e_rden;
    logic [AW-1:0] e_addr;
    logic          e_rd_valid;
    logic          e_rd_last;
    logic [DW-1:0] e_rd_data;
    logic          e_done;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  sram_burst_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  sram_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Behavioural sram: synchronous write, registered read that holds when rden is low.
  logic [DW-1:0] sram_mem [256];
  always @(posedge clk) begin
    if (bus.mem_wren) sram_mem[bus.mem_addr] <= bus.mem_wr_data;
    if (bus.mem_rden) bus.mem_rd_data <= sram_mem[bus.mem_addr];
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;
  endtask

  function automatic vec_t mk(
    input logic rv, input logic rw, input logic [AW-1:0] ra, input logic [LW-1:0] rl,
    input logic wv, input logic [DW-1:0] wd, input logic rr,
    input logic e_rq, input logic e_wr, input logic e_we, input logic e_re,
    input logic [AW-1:0] e_ad, input logic e_rv, input logic e_rl,
    input logic [DW-1:0] e_rd, input logic e_dn);
    vec_t v;
    v.req_valid = rv;   v.req_write = rw;   v.req_addr = ra;    v.req_len = rl;
    v.wr_valid = wv;    v.wr_data = wd;     v.rd_ready = rr;
    v.e_req_ready = e_rq; v.e_wr_ready = e_wr; v.e_wren = e_we; v.e_rden = e_re;
    v.e_addr = e_ad;    v.e_rd_valid = e_rv; v.e_rd_last = e_rl;
    v.e_rd_data = e_rd; v.e_done = e_dn;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    bus.req_valid = v.req_valid;
    bus.req_write = v.req_write;
    bus.req_addr  = v.req_addr;
    bus.req_len   = v.req_len;
    bus.wr_valid  = v.wr_valid;
    bus.wr_data   = v.wr_data;
    bus.rd_ready  = v.rd_ready;
    #1;
    check($sformatf("v%0d.req_ready", idx), 16'(bus.req_ready), 16'(v.e_req_ready));
    check($sformatf("v%0d.wr_ready", idx),  16'(bus.wr_ready),  16'(v.e_wr_ready));
    check($sformatf("v%0d.mem_wren", idx),  16'(bus.mem_wren),  16'(v.e_wren));
    check($sformatf("v%0d.mem_rden", idx),  16'(bus.mem_rden),  16'(v.e_rden));
    check($sformatf("v%0d.mem_addr", idx),  16'(bus.mem_addr),  16'(v.e_addr));
    check($sformatf("v%0d.rd_valid", idx),  16'(bus.rd_valid),  16'(v.e_rd_valid));
    check($sformatf("v%0d.rd_last", idx),   16'(bus.rd_last),   16'(v.e_rd_last));
    check($sformatf("v%0d.done", idx),      16'(bus.done),      16'(v.e_done));
    check($sformatf("v%0d.err", idx),       16'(bus.err),       16'h0);
    if (v.e_rd_valid) check($sformatf("v%0d.rd_data", idx), 16'(bus.rd_data), 16'(v.e_rd_data));
    if (v.e_wren) check($sformatf("v%0d.mem_wr_data", idx), 16'(bus.mem_wr_data), 16'(v.wr_data));
  endtask

  vec_t vecs [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd_exp [4];
    logic [AW-1:0] wrap_addr [4];
    logic          gap_valid [4];
    logic [AW-1:0] gap_addr [4];
    int            nbeats, ndone, nstall;
    logic          prev_stall;
    logic [DW-1:0] held;

    for (int i = 0; i < 256; i++) sram_mem[i] = '0;
    bus.mem_rd_data = '0;

    // Write 0x10 len 3, then back-to-back read of the same beats with rd_ready=1.
    //           rv rw addr   len wv wdata  rr  rq wr we re addr   rv rl rdata  dn
    vecs[0]  = mk(1, 1, 8'h10, 3, 0, 8'h00, 0,  1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0);
    vecs[1]  = mk(0, 0, 8'h00, 0, 1, 8'hA0, 0,  0, 1, 1, 0, 8'h10, 0, 0, 8'h00, 0);
    vecs[2]  = mk(0, 0, 8'h00, 0, 1, 8'hA1, 0,  0, 1, 1, 0, 8'h11, 0, 0, 8'h00, 0);
    vecs[3]  = mk(0, 0, 8'h00, 0, 1, 8'hA2, 0,  0, 1, 1, 0, 8'h12, 0, 0, 8'h00, 0);
    vecs[4]  = mk(0, 0, 8'h00, 0, 1, 8'hA3, 0,  0, 1, 1, 0, 8'h13, 0, 0, 8'h00, 0);
    vecs[5]  = mk(1, 0, 8'h10, 3, 0, 8'h00, 1,  1, 0, 0, 0, 8'h14, 0, 0, 8'h00, 1);
    vecs[6]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 1,  0, 0, 0, 1, 8'h10, 0, 0, 8'h00, 0);
    vecs[7]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 1,  0, 0, 0, 1, 8'h11, 1, 0, 8'hA0, 0);
    vecs[8]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 1,  0, 0, 0, 1, 8'h12, 1, 0, 8'hA1, 0);
    vecs[9]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 1,  0, 0, 0, 1, 8'h13, 1, 0, 8'hA2, 0);
    vecs[10] = mk(0, 0, 8'h00, 0, 0, 8'h00, 1,  0, 0, 0, 0, 8'h14, 1, 1, 8'hA3, 0);
    vecs[11] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0,  1, 0, 0, 0, 8'h14, 0, 0, 8'h00, 1);

    rd_exp    = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    wrap_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    gap_valid = '{1'b1, 1'b0, 1'b0, 1'b1};
    gap_addr  = '{8'h40, 8'h41, 8'h41, 8'h41};

    // Reset values.
    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst.req_ready", 16'(bus.req_ready), 16'h1);
    check("rst.wr_ready",  16'(bus.wr_ready),  16'h0);
    check("rst.rd_valid",  16'(bus.rd_valid),  16'h0);
    check("rst.rd_last",   16'(bus.rd_last),   16'h0);
    check("rst.done",      16'(bus.done),      16'h0);
    check("rst.err",       16'(bus.err),       16'h0);
    check("rst.mem_wren",  16'(bus.mem_wren),  16'h0);
    check("rst.mem_rden",  16'(bus.mem_rden),  16'h0);
    check("rst.mem_addr",  16'(bus.mem_addr),  16'h0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 12; i++) apply(vecs[i], i);

    // Read 0x10 len 3 with rd_ready toggling 1,0,1,0...
    @(negedge clk);
    idle_inputs();
    bus.req_valid = 1'b1;
    bus.req_addr  = 8'h10;
    bus.req_len   = 4'd3;
    #1;
    check("stall.req_ready", 16'(bus.req_ready), 16'h1);
    nbeats = 0; ndone = 0; nstall = 0; prev_stall = 1'b0; held = '0;
    for (int k = 0; k < 40 && ndone == 0; k++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.rd_ready  = (k % 2 == 0);
      #1;
      if (prev_stall) check("stall.rd_data_held", 16'(bus.rd_data), 16'(held));
      prev_stall = 1'b0;
      if (bus.rd_valid && !bus.rd_ready) begin
        check("stall.mem_rden_low", 16'(bus.mem_rden), 16'h0);
        prev_stall = 1'b1;
        held = bus.rd_data;
        nstall++;
      end
      if (bus.rd_valid && bus.rd_ready) begin
        if (nbeats < 4) begin
          check($sformatf("stall.beat%0d", nbeats), 16'(bus.rd_data), 16'(rd_exp[nbeats]));
          check($sformatf("stall.last%0d", nbeats), 16'(bus.rd_last), 16'(nbeats == 3));
        end
        nbeats++;
      end
      if (bus.done) ndone++;
    end
    check("stall.beats", 16'(nbeats), 16'd4);
    check("stall.done_pulses", 16'(ndone), 16'd1);
    check("stall.stalls_seen", 16'(nstall != 0), 16'h1);
    @(negedge clk);
    bus.rd_ready = 1'b0;
    #1;
    check("stall.done_one_cycle", 16'(bus.done), 16'h0);

    // Write 0x40 len 1 with wr_valid pattern 1,0,0,1.
    @(negedge clk);
    idle_inputs();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 8'h40;
    bus.req_len   = 4'd1;
    #1;
    check("gap.req_ready", 16'(bus.req_ready), 16'h1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.wr_valid  = gap_valid[k];
      bus.wr_data   = (k == 0) ? 8'hB0 : 8'hB1;
      #1;
      check($sformatf("gap.wr_ready%0d", k), 16'(bus.wr_ready), 16'h1);
      check($sformatf("gap.mem_wren%0d", k), 16'(bus.mem_wren), 16'(gap_valid[k]));
      check($sformatf("gap.mem_addr%0d", k), 16'(bus.mem_addr), 16'(gap_addr[k]));
    end
    @(negedge clk);
    bus.wr_valid = 1'b0;
    #1;
    check("gap.done", 16'(bus.done), 16'h1);
    check("gap.mem40", 16'(sram_mem[8'h40]), 16'h00B0);
    check("gap.mem41", 16'(sram_mem[8'h41]), 16'h00B1);

    // Read 0xFE len 3: wraps without the boundary check, rejected with it.
    @(negedge clk);
    idle_inputs();
    bus.req_valid = 1'b1;
    bus.req_addr  = 8'hFE;
    bus.req_len   = 4'd3;
    bus.rd_ready  = 1'b1;
    #1;
    check("wrap.req_ready", 16'(bus.req_ready), 16'h1);
`ifdef SRAM_BURST_BOUNDARY_CHECK_EN
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    check("oob.err", 16'(bus.err), 16'h1);
    check("oob.req_ready", 16'(bus.req_ready), 16'h1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("oob.mem_rden%0d", k), 16'(bus.mem_rden), 16'h0);
      check($sformatf("oob.mem_wren%0d", k), 16'(bus.mem_wren), 16'h0);
      check($sformatf("oob.done%0d", k), 16'(bus.done), 16'h0);
      @(negedge clk);
      #1;
    end
    check("oob.err_one_cycle", 16'(bus.err), 16'h0);
`else
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      #1;
      check($sformatf("wrap.mem_rden%0d", k), 16'(bus.mem_rden), 16'h1);
      check($sformatf("wrap.mem_addr%0d", k), 16'(bus.mem_addr), 16'(wrap_addr[k]));
    end
    @(negedge clk);
    #1;
    check("wrap.drain_rden", 16'(bus.mem_rden), 16'h0);
    check("wrap.rd_last", 16'(bus.rd_last), 16'h1);
    check("wrap.drain_addr", 16'(bus.mem_addr), 16'h02);
    @(negedge clk);
    #1;
    check("wrap.done", 16'(bus.done), 16'h1);
    check("wrap.err", 16'(bus.err), 16'h0);
`endif

    // Reset after 2 of 4 write beats, then a len-0 write.
    @(negedge clk);
    idle_inputs();
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 8'h20;
    bus.req_len   = 4'd3;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.wr_valid  = 1'b1;
    bus.wr_data   = 8'hC0;
    @(negedge clk);
    bus.wr_data   = 8'hC1;
    #1;
    check("rstmid.mem_addr_beat1", 16'(bus.mem_addr), 16'h21);
    @(negedge clk);
    bus.wr_data = 8'hC2;
    rstn = 1'b0;
    #1;
    check("rstmid.req_ready", 16'(bus.req_ready), 16'h1);
    check("rstmid.wr_ready",  16'(bus.wr_ready),  16'h0);
    check("rstmid.mem_wren",  16'(bus.mem_wren),  16'h0);
    check("rstmid.mem_rden",  16'(bus.mem_rden),  16'h0);
    check("rstmid.mem_addr",  16'(bus.mem_addr),  16'h0);
    check("rstmid.rd_valid",  16'(bus.rd_valid),  16'h0);
    check("rstmid.done",      16'(bus.done),      16'h0);
    check("rstmid.err",       16'(bus.err),       16'h0);
    @(negedge clk);
    rstn = 1'b1;
    bus.wr_valid = 1'b0;
    #1;
    check("rstmid.no_done", 16'(bus.done), 16'h0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 8'h30;
    bus.req_len   = 4'd0;
    #1;
    check("len0.req_ready", 16'(bus.req_ready), 16'h1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.wr_valid  = 1'b1;
    bus.wr_data   = 8'hD0;
    #1;
    check("len0.mem_wren", 16'(bus.mem_wren), 16'h1);
    check("len0.mem_addr", 16'(bus.mem_addr), 16'h30);
    check("len0.mem_wr_data", 16'(bus.mem_wr_data), 16'h00D0);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    #1;
    check("len0.done", 16'(bus.done), 16'h1);
    @(negedge clk);
    #1;
    check("len0.done_one_cycle", 16'(bus.done), 16'h0);
    check("len0.mem30", 16'(sram_mem[8'h30]), 16'h00D0);
    check("rstmid.mem22_untouched", 16'(sram_mem[8'h22]), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
